// File: rtl/three_xnor_logic_pkg.sv
// Shared definitions for the three-input XNOR leaf cell and its coverage monitor.
// The lane function lives here so the design and any reference model agree on it.
package three_xnor_pkg;

  // Number of distinct {a,b,c} combinations on a single lane.
  localparam int COMBOS = 8;

  function automatic logic xnor3(input logic a, input logic b, input logic c);
    return ~(a ^ b ^ c);
  endfunction

endpackage

// File: rtl/three_xnor_logic_sat_counter.sv
// Up-counter that holds at all-ones instead of wrapping; synchronous clear,
// asynchronous active-high reset.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic at_max;

  assign at_max = &count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !at_max) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/three_xnor_logic.sv
// Bitwise three-input XNOR with a registered copy, a saturating count of lane-0
// ones and a sticky map of the lane-0 input combinations seen so far.
module three_xnor_logic
  import three_xnor_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic [WIDTH-1:0]  c,
  output logic [WIDTH-1:0]  y,
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  output logic [WIDTH-1:0]  y_q,
  output logic [CNT_W-1:0]  ones_cnt,
  output logic [COMBOS-1:0] cov_map,
  output logic              cov_full
);

  logic [2:0]        combo;
  logic [COMBOS-1:0] combo_hit;
  logic [COMBOS-1:0] cov_map_next;

  // Purely combinational lanes: independent of clk, reset and clr.
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    assign y[i] = xnor3(a[i], b[i], c[i]);
  end

  assign combo        = {a[0], b[0], c[0]};
  assign combo_hit    = COMBOS'(1) << combo;
  assign cov_map_next = cov_map | combo_hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      y_q <= '0;
    end else begin
      y_q <= y;
    end
  end

  // cov_full looks at the next map so it rises on the edge the last bit sets.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cov_map  <= '0;
      cov_full <= 1'b0;
    end else if (clr) begin
      cov_map  <= '0;
      cov_full <= 1'b0;
    end else begin
      cov_map  <= cov_map_next;
      cov_full <= &cov_map_next;
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_ones_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .inc   (y[0]),
    .count (ones_cnt)
  );

endmodule

// File: tb/tb_three_xnor_logic.sv
// Bench for three_xnor_logic: three instances (WIDTH=1, WIDTH=1/CNT_W=2, WIDTH=4)
// share the inputs; a queue of expected outputs is checked on every falling edge.
module tb_three_xnor_logic;
  import three_xnor_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       clr;
  logic [3:0] a, b, c;

  logic        y1, yq1, full1;
  logic [15:0] cnt1;
  logic [7:0]  map1;
  logic        ys, yqs, fulls;
  logic [1:0]  cnts;
  logic [7:0]  maps;
  logic [3:0]  y4, yq4;
  logic        full4;
  logic [15:0] cnt4;
  logic [7:0]  map4;

  always #5 clk = ~clk;

  three_xnor_logic #(.WIDTH(1), .CNT_W(16)) dut (
    .a(a[0]), .b(b[0]), .c(c[0]), .y(y1),
    .clk(clk), .reset(reset), .clr(clr), .y_q(yq1),
    .ones_cnt(cnt1), .cov_map(map1), .cov_full(full1)
  );

  three_xnor_logic #(.WIDTH(1), .CNT_W(2)) dut_sat (
    .a(a[0]), .b(b[0]), .c(c[0]), .y(ys),
    .clk(clk), .reset(reset), .clr(clr), .y_q(yqs),
    .ones_cnt(cnts), .cov_map(maps), .cov_full(fulls)
  );

  three_xnor_logic #(.WIDTH(4), .CNT_W(16)) dut_w4 (
    .a(a), .b(b), .c(c), .y(y4),
    .clk(clk), .reset(reset), .clr(clr), .y_q(yq4),
    .ones_cnt(cnt4), .cov_map(map4), .cov_full(full4)
  );

  typedef struct packed {
    logic        y1;
    logic        yq1;
    logic [15:0] cnt16;
    logic [1:0]  cnt2;
    logic [7:0]  map;
    logic        full;
    logic [3:0]  y4;
    logic [3:0]  yq4;
  } exp_t;

  localparam int EXP_W = $bits(exp_t);

  logic [EXP_W-1:0] exp_q[$];
  exp_t             got;
  int               total = 0;
  int               bad   = 0;

  // Hand-written lane-0 truth table, indexed by {a,b,c}.
  logic [7:0] tt = 8'b0110_1001;

  logic        m_yq1;
  logic [15:0] m_cnt16;
  logic [1:0]  m_cnt2;
  logic [7:0]  m_map;
  logic        m_full;
  logic [3:0]  m_yq4;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] lanes4(input logic [3:0] va, input logic [3:0] vb,
                                        input logic [3:0] vc);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = xnor3(va[i], vb[i], vc[i]);
    return r;
  endfunction

  task automatic model_clear();
    m_yq1 = 1'b0; m_cnt16 = '0; m_cnt2 = '0; m_map = '0; m_full = 1'b0; m_yq4 = '0;
  endtask

  // Register update the DUT performs on a rising edge, using the held inputs.
  task automatic model_edge();
    logic [2:0] idx;
    idx = {a[0], b[0], c[0]};
    if (!reset) begin
      m_yq1 = tt[idx];
      m_yq4 = lanes4(a, b, c);
      if (clr) begin
        m_cnt16 = '0; m_cnt2 = '0; m_map = '0; m_full = 1'b0;
      end else begin
        if (tt[idx]) begin
          if (m_cnt16 != 16'hFFFF) m_cnt16 = m_cnt16 + 16'd1;
          if (m_cnt2 != 2'd3) m_cnt2 = m_cnt2 + 2'd1;
        end
        m_map  = m_map | (8'd1 << idx);
        m_full = (m_map == 8'hFF);
      end
    end
  endtask

  // Wait for a rising edge, advance the model, then drive new inputs 1 unit later.
  task automatic step(input logic [3:0] na, input logic [3:0] nb, input logic [3:0] nc,
                      input logic nclr, input logic nrst);
    exp_t       e;
    logic [2:0] idx;
    @(posedge clk);
    model_edge();
    #1;
    a = na; b = nb; c = nc; clr = nclr; reset = nrst;
    if (nrst) model_clear();
    idx     = {na[0], nb[0], nc[0]};
    e.y1    = tt[idx];
    e.yq1   = m_yq1;
    e.cnt16 = m_cnt16;
    e.cnt2  = m_cnt2;
    e.map   = m_map;
    e.full  = m_full;
    e.y4    = lanes4(na, nb, nc);
    e.yq4   = m_yq4;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      got = exp_q.pop_front();
      chk("y",          32'(y1),    32'(got.y1));
      chk("y_q",        32'(yq1),   32'(got.yq1));
      chk("ones_cnt",   32'(cnt1),  32'(got.cnt16));
      chk("cov_map",    32'(map1),  32'(got.map));
      chk("cov_full",   32'(full1), 32'(got.full));
      chk("sat_y",      32'(ys),    32'(got.y1));
      chk("sat_y_q",    32'(yqs),   32'(got.yq1));
      chk("sat_cnt",    32'(cnts),  32'(got.cnt2));
      chk("sat_map",    32'(maps),  32'(got.map));
      chk("sat_full",   32'(fulls), 32'(got.full));
      chk("w4_y",       32'(y4),    32'(got.y4));
      chk("w4_y_q",     32'(yq4),   32'(got.yq4));
      chk("w4_cnt",     32'(cnt4),  32'(got.cnt16));
      chk("w4_map",     32'(map4),  32'(got.map));
      chk("w4_full",    32'(full4), 32'(got.full));
    end
  end

  task automatic at_negedge();
    @(negedge clk);
    #1;
  endtask

  initial begin
    logic [2:0] kk;
    reset = 1'b1; clr = 1'b0; a = '0; b = '0; c = '0;
    model_clear();

    step(4'h0, 4'h0, 4'h0, 1'b0, 1'b1);
    step(4'h0, 4'h0, 4'h0, 1'b0, 1'b1);

    // Exhaustive lane-0 sweep, reset released on the first vector.
    for (int k = 0; k < 8; k++) begin
      kk = k[2:0];
      step({3'b0, kk[2]}, {3'b0, kk[1]}, {3'b0, kk[0]}, 1'b0, 1'b0);
    end
    step(4'h1, 4'h1, 4'h0, 1'b0, 1'b0);
    at_negedge();
    chk("sweep_map",  32'(map1),  32'hFF);
    chk("sweep_full", 32'(full1), 32'd1);
    chk("sweep_cnt",  32'(cnt1),  32'd4);

    // Reset raised between edges: registers clear before the next edge.
    step(4'h1, 4'h1, 4'h0, 1'b0, 1'b1);
    at_negedge();
    chk("rst_y",    32'(y1),    32'd1);
    chk("rst_y_q",  32'(yq1),   32'd0);
    chk("rst_cnt",  32'(cnt1),  32'd0);
    chk("rst_map",  32'(map1),  32'd0);
    chk("rst_full", 32'(full1), 32'd0);

    // Hold 000 for six sampled edges: the 2-bit counter saturates at 3.
    step(4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    repeat (6) step(4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    at_negedge();
    chk("sat6_cnt2", 32'(cnts), 32'd3);
    chk("sat6_cnt",  32'(cnt1), 32'd6);
    step(4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    at_negedge();
    chk("sat7_cnt2", 32'(cnts), 32'd3);
    chk("sat7_cnt",  32'(cnt1), 32'd7);

    // Clear with abc=000: the sample on the clear edge is not recorded.
    step(4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
    step(4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    at_negedge();
    chk("clr_cnt",  32'(cnt1),  32'd0);
    chk("clr_map",  32'(map1),  32'd0);
    chk("clr_full", 32'(full1), 32'd0);
    chk("clr_y_q",  32'(yq1),   32'd1);
    step(4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    at_negedge();
    chk("post_clr_map", 32'(map1), 32'd1);
    chk("post_clr_cnt", 32'(cnt1), 32'd1);

    // Multi-lane vectors.
    step(4'b1010, 4'b1100, 4'b0110, 1'b0, 1'b0);
    at_negedge();
    chk("w4_vec1", 32'(y4), 32'b1111);
    step(4'b1010, 4'b1100, 4'b0000, 1'b0, 1'b0);
    at_negedge();
    chk("w4_vec2", 32'(y4), 32'b1001);
    step(4'h0, 4'h0, 4'h0, 1'b0, 1'b0);

    for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain left=%0d required=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
